// File: rtl/biquad_incremental_pipe_if.sv
// Beat, coefficient and status signals of the incremental biquad pipeline.
// The slave side is the filter and the master side is the upstream driver.
interface biquad_incremental_pipe_if #(
    parameter int NSAMP      = 8,
    parameter int NBITS      = 16,
    parameter int NBITS2     = 24,
    parameter int OUTBITS    = 12,
    parameter int COEFF_BITS = 18
);
    logic [NBITS*NSAMP-1:0]   dat_i;
    logic [NBITS2-1:0]        y0_i;
    logic [NBITS2-1:0]        y1_i;
    logic                     valid_i;
    logic                     bypass_i;
    logic [COEFF_BITS-1:0]    coeff_dat_i;
    logic                     coeff_wr_i;
    logic                     coeff_update_i;
    logic                     sat_clr_i;
    logic [OUTBITS*NSAMP-1:0] dat_o;
    logic                     valid_o;
    logic                     sat_o;

    modport master (
        output dat_i, y0_i, y1_i, valid_i, bypass_i,
        output coeff_dat_i, coeff_wr_i, coeff_update_i, sat_clr_i,
        input  dat_o, valid_o, sat_o
    );

    modport slave (
        input  dat_i, y0_i, y1_i, valid_i, bypass_i,
        input  coeff_dat_i, coeff_wr_i, coeff_update_i, sat_clr_i,
        output dat_o, valid_o, sat_o
    );
endinterface

// File: rtl/biquad_incremental_pipe.sv
// All-pole recursion y[k] = x[k] + a1*y[k-1] + a2*y[k-2], one pipeline stage per sample,
// with per-beat coefficient sets, bypass, floor/saturate rounding and a sticky saturation flag.
module biquad_incremental_pipe #(
    parameter int NSAMP      = 8,
    parameter int NBITS      = 16,
    parameter int NFRAC      = 2,
    parameter int NBITS2     = 24,
    parameter int NFRAC2     = 10,
    parameter int OUTBITS    = 12,
    parameter int OUTFRAC    = 0,
    parameter int COEFF_BITS = 18,
    parameter int COEFF_FRAC = 14
) (
    input logic clk,
    input logic rst,
    biquad_incremental_pipe_if.slave bus
);
    localparam int L   = NSAMP - 1;
    localparam int PW  = COEFF_BITS + NBITS2;
    localparam int SW  = COEFF_BITS + NBITS2 + NBITS + OUTFRAC + 4;
    localparam int XSH = COEFF_FRAC + NFRAC2 - NFRAC;

    typedef logic signed [NBITS-1:0]      x_t;
    typedef logic signed [NBITS2-1:0]     y_t;
    typedef logic signed [COEFF_BITS-1:0] c_t;
    typedef logic signed [OUTBITS-1:0]    o_t;

    c_t sh_hi, sh_lo, a1, a2;

    // Stage s holds the whole beat; y[0..s] are valid in stage s.
    x_t   xs  [1:L][NSAMP];
    y_t   ys  [1:L][NSAMP];
    c_t   a1s [1:L-1];
    c_t   a2s [1:L-1];
    logic bps [1:L];
    logic vs  [1:L];

    y_t                       ynew [2:L];
    logic [OUTBITS*NSAMP-1:0] out_nxt;
    logic [OUTBITS*NSAMP-1:0] dat_q;
    logic                     valid_q;
    logic                     sat_q;
    logic                     sat_set;
    logic                     st;
    o_t                       o;

    function automatic logic signed [SW-1:0] clamp(input logic signed [SW-1:0] v,
                                                   input int unsigned bits,
                                                   output logic sat);
        logic signed [SW-1:0] mx, mn;
        mx    = (SW'(1) << (bits - 1)) - SW'(1);
        mn    = ~mx;
        sat   = 1'b0;
        clamp = v;
        if (v > mx) begin
            clamp = mx;
            sat   = 1'b1;
        end else if (v < mn) begin
            clamp = mn;
            sat   = 1'b1;
        end
    endfunction

    function automatic y_t biq_step(input x_t x, input y_t y1, input y_t y2,
                                    input c_t c1, input c_t c2, output logic sat);
        logic signed [PW-1:0] p1, p2;
        logic signed [SW-1:0] acc, r;
        p1  = PW'(c1) * PW'(y1);
        p2  = PW'(c2) * PW'(y2);
        acc = (SW'(x) <<< XSH) + SW'(p1) + SW'(p2);
        r   = clamp(acc >>> COEFF_FRAC, NBITS2, sat);
        biq_step = r[NBITS2-1:0];
    endfunction

    function automatic o_t fmt(input logic signed [SW-1:0] v, input int frac,
                               output logic sat);
        logic signed [SW-1:0] w;
        if (frac >= OUTFRAC) w = v >>> (frac - OUTFRAC);
        else                 w = v <<< (OUTFRAC - frac);
        w   = clamp(w, OUTBITS, sat);
        fmt = w[OUTBITS-1:0];
    endfunction

    always_comb begin
        sat_set = 1'b0;
        st      = 1'b0;
        o       = '0;
        out_nxt = '0;
        for (int unsigned s = 2; s <= L; s++) begin
            ynew[s] = biq_step(xs[s-1][s], ys[s-1][s-1], ys[s-1][s-2],
                               a1s[s-1], a2s[s-1], st);
            // Internal overflow only matters when the recursion result is emitted.
            if (st && vs[s-1] && !bps[s-1]) sat_set = 1'b1;
        end
        for (int unsigned k = 0; k < NSAMP; k++) begin
            if (bps[L]) o = fmt(SW'(xs[L][k]), NFRAC, st);
            else        o = fmt(SW'(ys[L][k]), NFRAC2, st);
            out_nxt[OUTBITS*k +: OUTBITS] = o;
            if (st && vs[L]) sat_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_hi   <= '0;
            sh_lo   <= '0;
            a1      <= '0;
            a2      <= '0;
            xs      <= '{default: '0};
            ys      <= '{default: '0};
            a1s     <= '{default: '0};
            a2s     <= '{default: '0};
            bps     <= '{default: 1'b0};
            vs      <= '{default: 1'b0};
            dat_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            // Update reads the shadow before this cycle's shift lands.
            if (bus.coeff_wr_i) begin
                sh_hi <= sh_lo;
                sh_lo <= bus.coeff_dat_i;
            end
            if (bus.coeff_update_i) begin
                a1 <= sh_hi;
                a2 <= sh_lo;
            end

            for (int unsigned k = 0; k < NSAMP; k++) begin
                xs[1][k] <= bus.dat_i[NBITS*k +: NBITS];
                ys[1][k] <= '0;
            end
            ys[1][0] <= bus.y0_i;
            ys[1][1] <= bus.y1_i;
            a1s[1]   <= a1;
            a2s[1]   <= a2;
            bps[1]   <= bus.bypass_i;
            vs[1]    <= bus.valid_i;

            for (int unsigned s = 2; s <= L; s++) begin
                xs[s]    <= xs[s-1];
                ys[s]    <= ys[s-1];
                ys[s][s] <= ynew[s];
                bps[s]   <= bps[s-1];
                vs[s]    <= vs[s-1];
            end
            for (int unsigned s = 2; s < L; s++) begin
                a1s[s] <= a1s[s-1];
                a2s[s] <= a2s[s-1];
            end

            dat_q   <= out_nxt;
            valid_q <= vs[L];
            if (sat_set)            sat_q <= 1'b1;
            else if (bus.sat_clr_i) sat_q <= 1'b0;
        end
    end

    assign bus.dat_o   = dat_q;
    assign bus.valid_o = valid_q;
    assign bus.sat_o   = sat_q;
endmodule

// File: tb/tb_biquad_incremental_pipe.sv
// Directed bench for biquad_incremental_pipe: passthrough, decay, coherent update,
// saturation, bypass and mid-flight reset, all against hand-computed values.
module tb_biquad_incremental_pipe;
    localparam int NSAMP      = 8;
    localparam int NBITS      = 16;
    localparam int NBITS2     = 24;
    localparam int OUTBITS    = 12;
    localparam int COEFF_BITS = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    biquad_incremental_pipe_if #(
        .NSAMP(NSAMP), .NBITS(NBITS), .NBITS2(NBITS2),
        .OUTBITS(OUTBITS), .COEFF_BITS(COEFF_BITS)
    ) bus ();

    biquad_incremental_pipe #(
        .NSAMP(NSAMP), .NBITS(NBITS), .NFRAC(2), .NBITS2(NBITS2), .NFRAC2(10),
        .OUTBITS(OUTBITS), .OUTFRAC(0), .COEFF_BITS(COEFF_BITS), .COEFF_FRAC(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int xv [NSAMP];
    int ev [NSAMP];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr_coeff(input int c);
        bus.coeff_dat_i = COEFF_BITS'(c);
        bus.coeff_wr_i  = 1'b1;
        @(negedge clk);
        bus.coeff_wr_i  = 1'b0;
    endtask

    task automatic upd_coeff();
        bus.coeff_update_i = 1'b1;
        @(negedge clk);
        bus.coeff_update_i = 1'b0;
    endtask

    task automatic load_beat(input int y0, input int y1, input logic bp, input logic upd);
        for (int k = 0; k < NSAMP; k++) bus.dat_i[NBITS*k +: NBITS] = NBITS'(xv[k]);
        bus.y0_i           = NBITS2'(y0);
        bus.y1_i           = NBITS2'(y1);
        bus.bypass_i       = bp;
        bus.valid_i        = 1'b1;
        bus.coeff_update_i = upd;
    endtask

    task automatic send(input int y0, input int y1, input logic bp, input logic upd);
        load_beat(y0, y1, bp, upd);
        @(negedge clk);
        bus.valid_i        = 1'b0;
        bus.coeff_update_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int lat_exp);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.valid_o && cnt < 20);
        check({tag, ".valid"}, int'(bus.valid_o), 1);
        check({tag, ".lat"}, cnt, lat_exp);
        for (int k = 0; k < NSAMP; k++)
            check($sformatf("%s[%0d]", tag, k),
                  int'($signed(bus.dat_o[OUTBITS*k +: OUTBITS])), ev[k]);
    endtask

    initial begin
        int seen;
        bus.dat_i = '0; bus.y0_i = '0; bus.y1_i = '0;
        bus.valid_i = 1'b0; bus.bypass_i = 1'b0;
        bus.coeff_dat_i = '0; bus.coeff_wr_i = 1'b0;
        bus.coeff_update_i = 1'b0; bus.sat_clr_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.valid_o", int'(bus.valid_o), 0);
        check("rst.dat_o_nz", int'(bus.dat_o != '0), 0);
        check("rst.sat_o", int'(bus.sat_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // Zero coefficients: every sample 5.0 passes straight through.
        xv = '{default: 16'h0014};
        ev = '{default: 5};
        send(24'h001400, 24'h001400, 1'b0, 1'b0);
        expect_out("pass", 7);

        // Negative values floor toward minus infinity.
        xv = '{default: 16'hFFFF};
        ev = '{default: -1};
        send(-1, -1024, 1'b0, 1'b0);
        expect_out("floor", 7);
        check("floor.sat_o", int'(bus.sat_o), 0);

        // a1 = 0.5, a2 = 0: geometric decay from y1 = 8.0.
        wr_coeff(32'h02000);
        wr_coeff(0);
        upd_coeff();
        xv = '{default: 0};
        ev = '{0, 8, 4, 2, 1, 0, 0, 0};
        send(0, 24'h002000, 1'b0, 1'b0);
        expect_out("decay", 7);
        check("decay.sat_o", int'(bus.sat_o), 0);

        // Update alongside beat A: A keeps the decay set, B gets the zero set.
        wr_coeff(0);
        wr_coeff(0);
        load_beat(0, 24'h002000, 1'b0, 1'b1);
        @(negedge clk);
        load_beat(0, 24'h002000, 1'b0, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        ev = '{0, 8, 4, 2, 1, 0, 0, 0};
        expect_out("coh_a", 6);
        ev = '{0, 8, 0, 0, 0, 0, 0, 0};
        expect_out("coh_b", 1);

        // a1 = 1.0: internal and output saturation, sticky flag, then clear.
        wr_coeff(32'h04000);
        wr_coeff(0);
        upd_coeff();
        xv = '{0, 0, 16'h7FFF, 0, 0, 0, 0, 0};
        ev = '{0, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
        send(0, 24'h1FFC00, 1'b0, 1'b0);
        expect_out("sat", 7);
        check("sat.sat_o", int'(bus.sat_o), 1);
        repeat (2) @(negedge clk);
        check("sat.sticky", int'(bus.sat_o), 1);
        bus.sat_clr_i = 1'b1;
        @(negedge clk);
        bus.sat_clr_i = 1'b0;
        check("sat.cleared", int'(bus.sat_o), 0);

        // Bypass ignores the nonzero coefficients.
        xv = '{0, 4, 8, 12, 16, 20, 24, 28};
        ev = '{0, 1, 2, 3, 4, 5, 6, 7};
        send(0, 0, 1'b1, 1'b0);
        expect_out("bypass", 7);
        check("bypass.sat_o", int'(bus.sat_o), 0);

        xv = '{0, 4, 8, 12, 16, 20, 16'h7FFF, 16'h8000};
        ev = '{0, 1, 2, 3, 4, 5, 2047, -2048};
        send(0, 0, 1'b1, 1'b0);
        expect_out("bypass_sat", 7);
        check("bypass_sat.sat_o", int'(bus.sat_o), 1);

        // Reset three cycles after entry drops the beat and the coefficients.
        xv = '{default: 16'h0014};
        send(24'h001400, 24'h001400, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_flight.sat_o", int'(bus.sat_o), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.valid_o) seen++;
        end
        check("rst_flight.valid_seen", seen, 0);
        ev = '{default: 5};
        send(24'h001400, 24'h001400, 1'b0, 1'b0);
        expect_out("rst_pass", 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/biquad_incremental_pipe.md
Name: biquad_incremental_pipe

Overview:
- Parametrised successor to the 8-sample incremental biquad stage.
- Takes one beat of NSAMP pre-filtered samples x[k] plus upstream-computed y[0], y[1], and runs the all-pole recursion y[k] = x[k] + a1*y[k-1] + a2*y[k-2] for k = 2..NSAMP-1 in a one-stage-per-sample pipeline.
- Adds a valid qualifier, beat-coherent coefficient updates (the coefficient set travels with each beat), a bypass mode, rounding/saturation rules, and a sticky saturation flag.
- Sits between the pole/y0-y1 precompute stage and the output formatter.

Parameters:
- NSAMP, 8, samples per beat (>=3)
- NBITS, 16, x sample width, signed
- NFRAC, 2, x fractional bits
- NBITS2, 24, y0/y1 and internal y width, signed
- NFRAC2, 10, internal y fractional bits
- OUTBITS, 12, output sample width, signed
- OUTFRAC, 0, output fractional bits
- COEFF_BITS, 18, coefficient width, signed
- COEFF_FRAC, 14, coefficient fractional bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dat_i  in  NBITS*NSAMP  x[k] at bits [NBITS*k +: NBITS]
- y0_i  in  NBITS2  y[0] of the same beat
- y1_i  in  NBITS2  y[1] of the same beat
- valid_i  in  1  beat qualifier for dat_i/y0_i/y1_i
- bypass_i  in  1  sampled with valid_i; beat passes x through
- coeff_dat_i  in  COEFF_BITS  coefficient write data
- coeff_wr_i  in  1  shift coeff_dat_i into shadow
- coeff_update_i  in  1  copy shadow to active
- sat_clr_i  in  1  clear sat_o
- dat_o  out  OUTBITS*NSAMP  y[k] at [OUTBITS*k +: OUTBITS]
- valid_o  out  1  dat_o qualifier
- sat_o  out  1  sticky saturation flag

Behaviour:
- Reset:
  - Shadow coefficients (sh_hi, sh_lo), active coefficients (a1, a2), all pipeline data and coefficient copies, and all valid bits go to 0.
  - dat_o=0, valid_o=0, sat_o=0.
- Coefficient shadow:
  - On coeff_wr_i: sh_hi<=sh_lo, sh_lo<=coeff_dat_i.
  - Program a1 first, then a2 (sh_hi->a1, sh_lo->a2).
- Update:
  - On coeff_update_i: a1<=sh_hi, a2<=sh_lo, effective the next cycle.
  - Simultaneous wr and update: update copies the pre-shift shadow; the write still shifts.
- Beat entry:
  - A beat entering when valid_i=1 captures {a1, a2, bypass_i} into stage 1.
  - The captured set is pipelined alongside the beat.
  - Every stage of that beat uses that set, so an update never mixes coefficient sets within a beat.
  - Invalid beats still advance the pipeline; valid rides along.
- Stage timing:
  - Stage k (k=2..NSAMP-1) registers y[k] at edge t+k-1, where t is the entry edge.
  - y[k] uses y[k-1] and y[k-2] from the previous stage registers.
  - y0/y1 and x values needed later are delayed in matching registers.
- Output and latency:
  - Final output-format register gives LAT = NSAMP-1 cycles.
  - A beat sampled with valid_i at edge t appears on dat_o with valid_o=1 after edge t+LAT.
  - Throughput is one beat per clock; no backpressure.
- Arithmetic:
  - Products a*y are exact at COEFF_FRAC+NFRAC2 fractional bits.
  - x is sign-extended and left-aligned to that fractional position.
  - The three-term sum is exact (width >= COEFF_BITS+NBITS2+2).
  - Result is floored (arithmetic right shift) to NFRAC2, then saturated to NBITS2.
  - Saturated y feeds the next stage.
- Output format:
  - Each y[k], including y0_i and y1_i, is floored to OUTFRAC and saturated to OUTBITS.
- Bypass:
  - Beat emits x[k] for all k, including k=0 and k=1, converted from NFRAC to OUTFRAC with the same floor/saturate rule.
  - Latency is unchanged.
- sat_o:
  - Set when any internal or output saturation occurs on a valid beat.
  - Cleared only by rst or sat_clr_i.
  - If clear and a new saturation occur in the same cycle, set wins.
- Reset mid-operation:
  - In-flight beats are discarded; valid_o stays 0 until LAT cycles after the first post-reset valid_i.

Test Plan:
- Post-reset passthrough: coeffs 0; all x=0x0014 (5.0); y0=y1=0x001400 -> after 7 cycles valid_o=1, all dat_o=5.
- Decay: write 0x02000 then 0x00000, update; x[k>=2]=0; y0=0, y1=0x002000 (8.0) -> dat_o = 0,8,4,2,1,0,0,0.
- Coherent update: beat A at cycle t, update pulse at t, beat B at t+1 with the decay set versus zero set -> A uses old coeffs, B uses new; no mixed outputs.
- Saturation: a1=0x04000 (1.0), a2=0; x[2]=0x7FFF; y1=0x1FFC00 -> dat_o[2]=2047, sat_o=1; sat_clr_i pulse -> sat_o=0.
- Bypass: bypass_i=1, x[k]=4k (value k), nonzero coeffs -> dat_o[k]=k for k=0..7, latency 7.
- Reset mid-flight: rst asserted 3 cycles after valid_i -> valid_o never asserts for that beat; coeffs read back as zero behaviour (passthrough test result).
